// File: rtl/axi_burst_slave.sv
// axi_burst_slave: AXI-style burst memory slave with independent read and
// write channels, INCR bursts of up to 16 beats, and per-beat out-of-range
// SLVERR responses.
// Optional build macro AXI_BURST_SLAVE_STRB_EN adds a WSTRB byte-lane
// write enable; without it every accepted write beat writes the full word.
module axi_burst_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [3:0]        ARLEN,
  input  logic [ID_W-1:0]   ARID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic              RLAST,
  output logic [1:0]        RRESP,
  output logic [ID_W-1:0]   RID,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [3:0]        AWLEN,
  input  logic [ID_W-1:0]   AWID,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
`ifdef AXI_BURST_SLAVE_STRB_EN
  input  logic [DATA_W/8-1:0] WSTRB,
`endif
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  output logic [ID_W-1:0]   BID
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_nxt;
  logic [3:0]        r_count;

  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_count;
  logic [ID_W-1:0]   w_id;
  logic              w_err;
  logic              w_hs;
  logic              w_beat_err;
  logic [NB-1:0]     wr_strb;

  // Addresses are widened by one bit so DEPTH == 2^ADDR_W compares correctly.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  assign r_addr_nxt = r_addr + ADDR_W'(1);
  assign w_hs       = WVALID && WREADY;
  assign w_beat_err = !in_range(w_addr) || (WLAST != (w_count == 4'd0));

`ifdef AXI_BURST_SLAVE_STRB_EN
  assign wr_strb = WSTRB;
`else
  assign wr_strb = '1;
`endif

  // Read data is an asynchronous look-up of the current beat address, so a
  // write landing on a clock edge is seen by the beat presented after it.
  assign RDATA = (RVALID && in_range(r_addr)) ? mem[r_addr[IDX_W-1:0]] : '0;

  // Read channel FSM: accept AR, then stream one beat per accepted R handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= RESP_OKAY;
      RID     <= '0;
      r_addr  <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            r_addr  <= ARADDR;
            r_count <= ARLEN;
            RID     <= ARID;
            RLAST   <= (ARLEN == 4'd0);
            RRESP   <= in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_count == 4'd0) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              RRESP   <= RESP_OKAY;
              RID     <= '0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr  <= r_addr_nxt;
              r_count <= r_count - 4'd1;
              RLAST   <= (r_count == 4'd1);
              RRESP   <= in_range(r_addr_nxt) ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel FSM: accept AW, take exactly AWLEN+1 beats, then respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      BID     <= '0;
      w_addr  <= '0;
      w_count <= '0;
      w_id    <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            w_addr  <= AWADDR;
            w_count <= AWLEN;
            w_id    <= AWID;
            w_err   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_count == 4'd0) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              BRESP   <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_addr  <= w_addr + ADDR_W'(1);
              w_count <= w_count - 4'd1;
              w_err   <= w_err || w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            BID     <= '0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage array: byte-lane writes for in-range beats, never reset.
  always_ff @(posedge clk) begin
    if (w_hs && in_range(w_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) begin
          mem[w_addr[IDX_W-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_slave.sv
// tb_axi_burst_slave: directed bench for axi_burst_slave with a small
// reference memory; covers bursts, backpressure, range errors, WLAST misuse,
// address wrap, concurrent channels, mid-burst reset and (when built with
// AXI_BURST_SLAVE_STRB_EN) byte strobes.
module tb_axi_burst_slave;

`ifdef AXI_BURST_SLAVE_STRB_EN
  localparam int DATA_W = 16;
`else
  localparam int DATA_W = 8;
`endif
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;
  localparam int ID_W   = 4;

  logic              clk;
  logic              rst;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [3:0]        ARLEN;
  logic [ID_W-1:0]   ARID;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic [1:0]        RRESP;
  logic [ID_W-1:0]   RID;
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [3:0]        AWLEN;
  logic [ID_W-1:0]   AWID;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
`ifdef AXI_BURST_SLAVE_STRB_EN
  logic [DATA_W/8-1:0] WSTRB;
`endif
  logic              WLAST;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;
  logic [ID_W-1:0]   BID;

  logic [DATA_W-1:0] model_mem [256];
  logic [DATA_W-1:0] wbuf [16];
  logic [DATA_W-1:0] wbuf2 [16];
  int vec_count;
  int miss_count;

  axi_burst_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP), .RID(RID),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
`ifdef AXI_BURST_SLAVE_STRB_EN
    .WSTRB(WSTRB),
`endif
    .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Write burst from wbuf; WLAST is raised on beat index last_beat.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                               input logic [ID_W-1:0] id, input int last_beat,
                               input logic [1:0] exp_resp, input bit use_buf2);
    int n;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    AWVALID = 1'b1; AWADDR = addr; AWLEN = len; AWID = id;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    checkOutput("awready", 32'(AWREADY), 32'd1);
    @(posedge clk); #1 AWVALID = 1'b0;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      d = use_buf2 ? wbuf2[i] : wbuf[i];
      @(negedge clk);
      WVALID = 1'b1; WDATA = d; WLAST = (i == last_beat);
      n = 0;
      while (!WREADY && n < 50) begin @(negedge clk); n++; end
      checkOutput("wready", 32'(WREADY), 32'd1);
      @(posedge clk); #1 WVALID = 1'b0; WLAST = 1'b0;
      if (int'(a) < DEPTH) model_mem[a] = d;
      a = a + 8'd1;
    end
    BREADY = 1'b1;
    @(negedge clk);
    n = 0;
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    checkOutput("bvalid", 32'(BVALID), 32'd1);
    checkOutput("bresp", 32'(BRESP), 32'(exp_resp));
    checkOutput("bid", 32'(BID), 32'(id));
    @(posedge clk); #1 BREADY = 1'b0;
    @(negedge clk);
    checkOutput("bvalid_end", 32'(BVALID), 32'd0);
    checkOutput("awready_end", 32'(AWREADY), 32'd1);
  endtask

  // Read burst; RREADY follows pat[] over cycles where RVALID is high, and
  // every presented beat (including stalled repeats) is checked.
  task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [3:0] len,
                            input logic [ID_W-1:0] id, input logic [3:0] pat);
    int n, b, c;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] exp_data;
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    checkOutput("arready", 32'(ARREADY), 32'd1);
    @(posedge clk); #1 ARVALID = 1'b0;
    b = 0; c = 0; n = 0;
    while (b <= int'(len) && n < 200) begin
      @(negedge clk);
      n++;
      if (RVALID) begin
        RREADY = pat[c % 4];
        c++;
        a = addr + 8'(b);
        exp_data = (int'(a) < DEPTH) ? model_mem[a] : '0;
        checkOutput("rdata", 32'(RDATA), 32'(exp_data));
        checkOutput("rresp", 32'(RRESP), (int'(a) < DEPTH) ? 32'd0 : 32'd2);
        checkOutput("rlast", 32'(RLAST), 32'(b == int'(len)));
        checkOutput("rid", 32'(RID), 32'(id));
        if (RREADY) b++;
      end else begin
        RREADY = 1'b0;
      end
    end
    checkOutput("r_beats", 32'(b), 32'(int'(len) + 1));
    @(posedge clk); #1 RREADY = 1'b0;
    @(negedge clk);
    checkOutput("rvalid_end", 32'(RVALID), 32'd0);
    checkOutput("arready_end", 32'(ARREADY), 32'd1);
  endtask

  // Main directed sequence.
  initial begin
    vec_count = 0; miss_count = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    rst = 1'b0;
    ARVALID = 0; ARADDR = '0; ARLEN = '0; ARID = '0; RREADY = 0;
    AWVALID = 0; AWADDR = '0; AWLEN = '0; AWID = '0;
    WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 0;
`ifdef AXI_BURST_SLAVE_STRB_EN
    WSTRB = '1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_arready", 32'(ARREADY), 32'd1);
    checkOutput("rst_awready", 32'(AWREADY), 32'd1);
    checkOutput("rst_rvalid", 32'(RVALID), 32'd0);
    checkOutput("rst_wready", 32'(WREADY), 32'd0);
    checkOutput("rst_bvalid", 32'(BVALID), 32'd0);
    checkOutput("rst_rlast", 32'(RLAST), 32'd0);
    checkOutput("rst_rdata", 32'(RDATA), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rel_arready", 32'(ARREADY), 32'd1);

    // Basic three-beat write then readback.
    wbuf[0] = 'h01; wbuf[1] = 'h02; wbuf[2] = 'h03;
    applyStimulus(8'd1, 4'd2, 4'hA, 2, 2'b00, 1'b0);
    read_burst(8'd1, 4'd2, 4'h6, 4'b1111);

    // Read backpressure with RREADY 1,0,0,1.
    wbuf[0] = 'h41; wbuf[1] = 'h42; wbuf[2] = 'h43; wbuf[3] = 'h44;
    applyStimulus(8'd10, 4'd3, 4'h3, 3, 2'b00, 1'b0);
    read_burst(8'd10, 4'd3, 4'h7, 4'b1001);

    // Burst crossing the top of the implemented range.
    wbuf[0] = 'h11; wbuf[1] = 'h22; wbuf[2] = 'h33; wbuf[3] = 'h44;
    applyStimulus(8'd62, 4'd3, 4'h1, 3, 2'b10, 1'b0);
    read_burst(8'd62, 4'd3, 4'h2, 4'b1111);

    // WLAST raised early: all three beats still taken, SLVERR reported.
    wbuf[0] = 'h71; wbuf[1] = 'h72; wbuf[2] = 'h73;
    applyStimulus(8'd30, 4'd2, 4'h4, 1, 2'b10, 1'b0);
    read_burst(8'd30, 4'd2, 4'h4, 4'b1111);

    // Address wrap past 255 back to 0.
    wbuf[0] = 'h5A; wbuf[1] = 'h5B;
    applyStimulus(8'd255, 4'd1, 4'h5, 1, 2'b10, 1'b0);
    read_burst(8'd254, 4'd3, 4'h8, 4'b1111);

    // Independent channels running at once on disjoint addresses.
    wbuf2[0] = 'h61; wbuf2[1] = 'h62; wbuf2[2] = 'h63; wbuf2[3] = 'h64;
    fork
      applyStimulus(8'd20, 4'd3, 4'h3, 3, 2'b00, 1'b1);
      read_burst(8'd10, 4'd3, 4'h9, 4'b1011);
    join
    read_burst(8'd20, 4'd3, 4'hC, 4'b1111);

    // Reset asserted in the middle of a read burst.
    @(negedge clk);
    ARVALID = 1'b1; ARADDR = 8'd1; ARLEN = 4'd7; ARID = 4'h5;
    @(posedge clk); #1 ARVALID = 1'b0; RREADY = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mid_rvalid_pre", 32'(RVALID), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rvalid", 32'(RVALID), 32'd0);
    checkOutput("mid_arready", 32'(ARREADY), 32'd1);
    RREADY = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checkOutput("post_arready", 32'(ARREADY), 32'd1);
    checkOutput("post_rvalid", 32'(RVALID), 32'd0);
    read_burst(8'd1, 4'd2, 4'hD, 4'b1111);

`ifdef AXI_BURST_SLAVE_STRB_EN
    // Byte strobes: low lane only, then an all-zero no-op beat.
    wbuf[0] = 'h1234;
    applyStimulus(8'd5, 4'd0, 4'h1, 0, 2'b00, 1'b0);
    WSTRB = 2'b01; wbuf[0] = 'hAAAA;
    applyStimulus(8'd5, 4'd0, 4'h2, 0, 2'b00, 1'b0);
    model_mem[5] = 'h12AA;
    read_burst(8'd5, 4'd0, 4'h3, 4'b1111);
    WSTRB = 2'b00; wbuf[0] = 'hFFFF;
    applyStimulus(8'd5, 4'd0, 4'h4, 0, 2'b00, 1'b0);
    model_mem[5] = 'h12AA;
    read_burst(8'd5, 4'd0, 4'h5, 4'b1111);
    WSTRB = '1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/axi_burst_slave.md
Name: axi_burst_slave

Overview:
- Parametrised AXI-style memory slave: next generation of the single-beat Master/Slave pair.
- Independent read and write channels, each accepting INCR bursts of up to 16 beats.
- Configurable data/address/ID widths and memory depth; per-beat out-of-range error responses.
- Sits behind the Master as the system's addressable storage target.

Parameters:
DATA_W, 8, data bus width in bits (multiple of 8)
ADDR_W, 8, word address width
DEPTH, 64, implemented words (DEPTH <= 2^ADDR_W); addresses >= DEPTH are out of range
ID_W, 4, transaction ID width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
ARADDR  in  ADDR_W  read start word address
ARLEN  in  4  read beats minus one
ARID  in  ID_W  read ID
RVALID  out  1  read data valid
RREADY  in  1  read data ready
RDATA  out  DATA_W  read data
RLAST  out  1  final read beat
RRESP  out  2  read response: 00 OKAY, 10 SLVERR
RID  out  ID_W  echoed ARID
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWADDR  in  ADDR_W  write start word address
AWLEN  in  4  write beats minus one
AWID  in  ID_W  write ID
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_W  write data
WLAST  in  1  master's last-beat flag
BVALID  out  1  write response valid
BREADY  in  1  write response ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BID  out  ID_W  echoed AWID

Behaviour:
- Reset (rst=0, async): both FSMs to idle. ARREADY=1, AWREADY=1; all other outputs 0. Memory contents not reset.
- Handshake: transfer occurs on a rising edge with VALID&READY both high. A raised VALID holds its payload until accepted. The slave never waits for READY before asserting VALID.
- Read FSM R_IDLE/R_DATA:
  - R_IDLE: ARREADY=1. On the AR handshake, latch addr, ID and count=ARLEN; go to R_DATA.
  - R_DATA: ARREADY=0. RVALID=1 from the cycle after the AR handshake (1-cycle latency). RDATA=mem[addr], RID=latched ID, RLAST=(count==0).
  - Each R handshake increments addr and decrements count. The next beat is valid the following cycle (1 beat/cycle).
  - The handshake with RLAST=1 returns to R_IDLE; ARREADY=1 the next cycle.
  - Beat addr >= DEPTH: RDATA=0, RRESP=10 for that beat only. The burst continues.
- Write FSM W_IDLE/W_DATA/W_RESP:
  - W_IDLE: AWREADY=1. On the AW handshake, latch addr, ID and count=AWLEN; clear err; go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes WDATA to mem[addr] if addr < DEPTH; otherwise the data is dropped and err is set.
  - WLAST must equal (count==0) on every beat; a mismatch sets err. The burst ends on the beat count only, not on WLAST.
  - After the final beat, go to W_RESP: BVALID=1, BID=latched ID, BRESP=err?10:00. Hold until BREADY; then W_IDLE.
- Address arithmetic: addr increments modulo 2^ADDR_W. Wrap past the top is legal; wrapped addresses are range-checked independently.
- Concurrency: read and write FSMs are fully independent. A same-cycle read and write to one address returns old data; the write is visible from the next cycle.
- Mid-burst reset: the burst is abandoned and no response is issued; words already written are kept.

Optional Feature:
- Macro AXI_BURST_SLAVE_STRB_EN.
- Defined: adds input WSTRB, width DATA_W/8. Only byte lanes whose strobe is 1 are written. An all-zero strobe is a legal no-op beat that still counts toward the burst.
- Undefined: no WSTRB port; every accepted beat writes the full word.

Test Plan:
- Write burst AWADDR=1, AWLEN=2, WDATA 1,2,3, WLAST on beat 3 -> BRESP=00, BID=AWID. Read ARADDR=1, ARLEN=2 -> RDATA 1,2,3, RLAST on beat 3 only, RRESP=00.
- Read backpressure: ARLEN=3, RREADY toggling 1,0,0,1 -> RDATA/RLAST held stable while stalled; exactly 4 beats delivered in address order.
- Range error: DEPTH=64, write AWADDR=62, AWLEN=3 -> mem[62],mem[63] updated, BRESP=10. Read ARADDR=62, ARLEN=3 -> RRESP 00,00,10,10, RDATA beats 3-4 = 0.
- WLAST misuse: AWLEN=2 with WLAST on beat 2 -> 3 beats still accepted, BRESP=10.
- Concurrency and reset: read burst during a write burst -> both complete with correct IDs. Assert rst low mid-read -> RVALID=0 immediately, ARREADY=1 after release.
- STRB_EN build: write 16'hAAAA with WSTRB=01 over 16'h1234 (DATA_W=16) -> readback 16'h12AA.
